// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running bit-period counter with an end-of-bit strobe
//                and a synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_bit_end = w_bit_end;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core
//  Description : 8N1 UART transmitter with a one-entry holding register so
//                back-to-back bytes leave with no idle gap. Define
//                UART_TX_PARITY_EN to insert a parity bit (8E1 / 8O1).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic                 r_stop_idx;
    logic                 w_stop_idx_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_full;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_done;
    logic                 w_bit_end;
    logic                 w_baud_clr;
    logic                 w_stop_last;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    assign w_push      = tx_valid && !r_hold_full;
    assign w_baud_clr  = (r_state == IDLE);
    assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_baud_clr),
        .o_bit_end (w_bit_end)
    );

    // tx is computed for the *next* cycle so the line itself comes straight
    // off a flop; every transition below sets w_tx_next for the entered bit.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_tx_next       = r_tx;
        w_pop           = 1'b0;
        w_done          = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (r_hold_full) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_hold_data;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = 3'd0;
                    w_tx_next      = r_shift[0];
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next    = PARITY;
                        w_tx_next       = r_parity;
`else
                        w_state_next    = STOP;
                        w_tx_next       = 1'b1;
                        w_stop_idx_next = 1'b0;
`endif
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next    = STOP;
                    w_tx_next       = 1'b1;
                    w_stop_idx_next = 1'b0;
                end
            end
`endif

            STOP: begin
                if (w_bit_end) begin
                    if (w_stop_last) begin
                        w_done = 1'b1;
                        if (r_hold_full) begin
                            w_pop        = 1'b1;
                            w_shift_next = r_hold_data;
                            w_state_next = START;
                            w_tx_next    = 1'b0;
                        end else begin
                            w_state_next = IDLE;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_idx   <= 3'd0;
            r_stop_idx  <= 1'b0;
            r_tx        <= 1'b1;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            // A push in the same cycle as a pop keeps the slot full.
            if (w_push) begin
                r_hold_data <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_pop) begin
                r_hold_full <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured when the byte leaves the holding register because
    // the shift register is consumed bit by bit during DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= (^r_hold_data) ^ PARITY_ODD;
        end
    end
`endif

    assign tx_ready = !r_hold_full;
    assign tx       = r_tx;
    assign busy     = (r_state != IDLE) || r_hold_full;
    assign done     = w_done;

endmodule : uart_tx_core
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_core
//  Description : Directed self-checking bench for uart_tx_core
//                (CLKS_PER_BIT=8; STOP_BITS=1 and 2; parity builds too).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       vld0, vld1;
    logic       rdy0, rdy1, tx0, tx1, busy0, busy1, done0, done1;
`ifdef UART_TX_PARITY_EN
    logic       vld2, rdy2, tx2, busy2, done2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld0),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld1),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(vld2),
        .tx_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2)
    );
`endif

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return tx0;
            1: return tx1;
`ifdef UART_TX_PARITY_EN
            2: return tx2;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic rdy_of(input int sel);
        case (sel)
            0: return rdy0;
            1: return rdy1;
`ifdef UART_TX_PARITY_EN
            2: return rdy2;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
`ifdef UART_TX_PARITY_EN
            2: return busy2;
`endif
            default: return 1'bx;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
`ifdef UART_TX_PARITY_EN
            2: return done2;
`endif
            default: return 1'bx;
        endcase
    endfunction

    task automatic set_vld(input int sel, input logic v);
        case (sel)
            0: vld0 = v;
            1: vld1 = v;
`ifdef UART_TX_PARITY_EN
            2: vld2 = v;
`endif
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until the transfer edge; returns #1 after that edge.
    task automatic push(input int sel, input logic [7:0] d);
        logic r;
        int   n;
        n = 0;
        r = 1'b0;
        tx_data = d;
        set_vld(sel, 1'b1);
        while (!r && n < 400) begin
            r = rdy_of(sel);
            tick;
            n++;
        end
        set_vld(sel, 1'b0);
        check("push_accepted", r, 1'b1);
    endtask

    // Waits for the start bit, then checks every bit lasts exactly CPB clocks.
    task automatic check_frame(input int sel, input logic [7:0] d, input logic par,
                               input int stops, output int waited);
        logic exp_bits [0:11];
        int   nb;
        int   dcnt;
        logic dpos;
        logic ok;
        waited = 0;
        while (tx_of(sel) !== 1'b0 && waited < 400) begin
            tick;
            waited++;
        end
        check("start_seen", tx_of(sel), 1'b0);
        nb = 0;
        exp_bits[nb] = 1'b0;
        nb++;
        for (int i = 0; i < 8; i++) begin
            exp_bits[nb] = d[i];
            nb++;
        end
        if (c_PAR != 0) begin
            exp_bits[nb] = par;
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        dcnt = 0;
        dpos = 1'b0;
        for (int b = 0; b < nb; b++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (tx_of(sel) !== exp_bits[b]) ok = 1'b0;
                if (done_of(sel) === 1'b1) begin
                    dcnt++;
                    if (b == nb - 1 && c == CPB - 1) dpos = 1'b1;
                end
                tick;
            end
            check($sformatf("frame_%02h_bit%0d", d, b), ok, 1'b1);
        end
        check("done_count", dcnt, 1);
        check("done_on_last_clk", dpos, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w, w1, w2;
        logic ok;
        rst     = 1'b1;
        tx_data = 8'h00;
        vld0    = 1'b0;
        vld1    = 1'b0;
`ifdef UART_TX_PARITY_EN
        vld2    = 1'b0;
`endif
        repeat (3) tick;
        check("rst_tx", tx0, 1'b1);
        check("rst_ready", rdy0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        rst = 1'b0;
        tick;

        // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1
        push(0, 8'hA5);
        check("a5_ready_held", rdy0, 1'b0);
        check("a5_busy_held", busy0, 1'b1);
        check("a5_tx_idle", tx0, 1'b1);
        check_frame(0, 8'hA5, 1'b0, 1, w);
        check("a5_latency", w, 1);
        check("a5_busy_after", busy0, 1'b0);
        check("a5_tx_after", tx0, 1'b1);
        check("a5_ready_after", rdy0, 1'b1);

        // Back-to-back 0x00 then 0xFF, second pushed mid-DATA
        push(0, 8'h00);
        fork
            begin
                check_frame(0, 8'h00, 1'b0, 1, w1);
                check_frame(0, 8'hFF, 1'b0, 1, w2);
                check("b2b_gap", w2, 0);
            end
            begin
                repeat (20) tick;
                push(0, 8'hFF);
                check("b2b_ready_after_push", rdy0, 1'b0);
                check("b2b_busy", busy0, 1'b1);
            end
        join
        check("b2b_busy_after", busy0, 1'b0);

        // tx_valid held with changing data: only 0x11 and 0x33 transfer
        fork
            begin
                tx_data = 8'h11;
                vld0    = 1'b1;
                check("hold_rdy_e1", rdy0, 1'b1);
                tick;
                check("hold_rdy_e2", rdy0, 1'b0);
                tx_data = 8'h22;
                tick;
                check("hold_rdy_e3", rdy0, 1'b1);
                tx_data = 8'h33;
                tick;
                check("hold_rdy_e4", rdy0, 1'b0);
                tx_data = 8'h44;
                tick;
                vld0 = 1'b0;
            end
            begin
                check_frame(0, 8'h11, 1'b0, 1, w1);
                check_frame(0, 8'h33, 1'b0, 1, w2);
                check("hold_gap", w2, 0);
            end
        join
        ok = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (tx0 !== 1'b1 || busy0 !== 1'b0) ok = 1'b0;
            tick;
        end
        check("hold_no_extra_frame", ok, 1'b1);

        // Reset during DATA of 0x3C (bit1 = 0 on the line), then 0x81
        push(0, 8'h3C);
        repeat (22) tick;
        check("abort_pre_rst_low", tx0, 1'b0);
        rst = 1'b1;
        tick;
        check("abort_tx", tx0, 1'b1);
        check("abort_ready", rdy0, 1'b1);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        rst = 1'b0;
        tick;
        push(0, 8'h81);
        check_frame(0, 8'h81, 1'b0, 1, w);
        check("r81_latency", w, 1);
        check("r81_busy_after", busy0, 1'b0);

        // Two stop bits, 0x55
        push(1, 8'h55);
        check_frame(1, 8'h55, 1'b0, 2, w);
        check("s2_latency", w, 1);
        check("s2_busy_after", busy1, 1'b0);
        check("s2_tx_after", tx1, 1'b1);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; odd parity inverts both
        push(0, 8'h07);
        check_frame(0, 8'h07, 1'b1, 1, w);
        push(0, 8'h03);
        check_frame(0, 8'h03, 1'b0, 1, w);
        push(2, 8'h07);
        check_frame(2, 8'h07, 1'b0, 1, w);
        push(2, 8'h03);
        check_frame(2, 8'h03, 1'b1, 1, w);
        check("odd_busy_after", busy2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_core
`default_nettype wire
